// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and 8N1 frame constants.
// uart_rx and uart_tx both import this package.
package uart_pkg;

    typedef enum logic [2:0] {
        s_IDLE    = 3'd0,
        s_START   = 3'd1,
        s_DATA    = 3'd2,
        s_STOP    = 3'd3,
        s_CLEANUP = 3'd4
    } uart_state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value is a parameter so an idle-high line resets to high.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples mid-bit, reports each good byte with a one-cycle
// strobe and a bad stop bit with a one-cycle frame-error strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx_serial,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_busy,
    output logic       o_frame_err
);

    localparam logic [CNT_W-1:0]     FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]     HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    logic rx_s;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (i_rx_serial),
        .q_o  (rx_s)
    );

    uart_state_e                state_q,   state_d;
    logic [CNT_W-1:0]           timer_q,   timer_d;
    logic [BIT_IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]       shift_q,   shift_d;
    logic [7:0]                 byte_q,    byte_d;
    logic                       dv_q,      dv_d;
    logic                       ferr_q,    ferr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= s_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= 8'h00;
            dv_q      <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        dv_d      = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            s_IDLE: begin
                timer_d   = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = s_START;
                end
            end

            // A start bit that is high again at its midpoint was only a glitch.
            s_START: begin
                if (timer_q == HALF_BIT) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? s_IDLE : s_DATA;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            s_DATA: begin
                if (timer_q == FULL_BIT) begin
                    timer_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
                        state_d   = s_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            s_STOP: begin
                if (timer_q == FULL_BIT) begin
                    timer_d = '0;
                    state_d = s_CLEANUP;
                    if (rx_s) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end

            // Wait for a high line so a break is never mistaken for a new start bit.
            s_CLEANUP: begin
                timer_d = '0;
                if (rx_s) begin
                    state_d = s_IDLE;
                end
            end

            default: begin
                state_d   = s_IDLE;
                timer_d   = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    assign o_rx_dv     = dv_q;
    assign o_rx_byte   = byte_q;
    assign o_frame_err = ferr_q;
    assign o_rx_busy   = (state_q != s_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clk/bit: a time-based serial transmitter drives the
// pin, expected events go into a queue and a negedge monitor checks each strobe.
`timescale 1ps/1ps
module tb_uart_rx;

    localparam int CPB      = 16;
    localparam int CLK_PS   = 10000;
    localparam int NOM_BIT  = CPB * CLK_PS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       o_rx_dv;
    logic [7:0] o_rx_byte;
    logic       o_rx_busy;
    logic       o_frame_err;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    // Expected strobe events: {frame_err, byte visible on o_rx_byte}.
    logic [8:0] exp_q[$];
    int         dv_cyc_q[$];
    logic [7:0] last_good = 8'h00;
    int         good_sent = 0;
    int         err_sent  = 0;
    int         dv_count  = 0;
    int         ferr_count = 0;
    logic       prev_strobe = 1'b0;

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rx_serial(rx),
        .o_rx_dv    (o_rx_dv),
        .o_rx_byte  (o_rx_byte),
        .o_rx_busy  (o_rx_busy),
        .o_frame_err(o_frame_err)
    );

    always #(CLK_PS / 2) clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n && (o_rx_dv || o_frame_err)) begin
            n_checks++;
            if (o_rx_dv && o_frame_err) begin
                n_fails++;
                $display("FAIL strobe_overlap: dv=%0b ferr=%0b, required not both", o_rx_dv, o_frame_err);
            end
            n_checks++;
            if (prev_strobe) begin
                n_fails++;
                $display("FAIL strobe_width: strobe high for 2+ cycles at cyc %0d, required 1", cyc);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_strobe: got ferr=%0b byte=%02h, required no strobe", o_frame_err, o_rx_byte);
            end else begin
                logic [8:0] exp;
                exp = exp_q.pop_front();
                if ({o_frame_err, o_rx_byte} !== exp) begin
                    n_fails++;
                    $display("FAIL rx_event: got ferr=%0b byte=%02h, required ferr=%0b byte=%02h",
                             o_frame_err, o_rx_byte, exp[8], exp[7:0]);
                end
            end
            if (o_rx_dv) begin
                dv_count++;
                dv_cyc_q.push_back(cyc);
            end
            if (o_frame_err) ferr_count++;
        end
        prev_strobe = rst_n && (o_rx_dv || o_frame_err);
    end

    task automatic check(input string name, input int actual, input int required);
        n_checks++;
        if (actual != required) begin
            n_fails++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    // Serial transmitter; stop_low > 0 holds the stop bit low for that many bit times.
    task automatic send_frame(input logic [7:0] b, input int bit_ps, input int stop_low);
        rx = 1'b0;
        #(bit_ps);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ps);
        end
        if (stop_low > 0) begin
            rx = 1'b0;
            #(bit_ps * stop_low);
            rx = 1'b1;
        end else begin
            rx = 1'b1;
            #(bit_ps);
        end
    endtask

    task automatic send_good(input logic [7:0] b, input int bit_ps);
        exp_q.push_back({1'b0, b});
        last_good = b;
        good_sent++;
        send_frame(b, bit_ps, 0);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check({name, "_drain_timeout"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic quiet_window(input string name, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_rx_dv || o_frame_err || o_rx_busy || (o_rx_byte !== last_good)) begin
                if (bad == 0)
                    $display("FAIL %s: dv=%0b ferr=%0b busy=%0b byte=%02h, required 0/0/0/%02h",
                             name, o_rx_dv, o_frame_err, o_rx_busy, o_rx_byte, last_good);
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) n_fails++;
    endtask

    initial begin
        int fall_cyc;
        int busy_cycles;
        int skew;

        // Reset and idle line.
        repeat (3) @(posedge clk);
        #1;
        check("reset_byte", int'(o_rx_byte), 0);
        check("reset_busy", int'(o_rx_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet_window("idle_quiet", 500);

        // Back-to-back A5, 3C with latency and spacing checks.
        dv_cyc_q.delete();
        @(posedge clk);
        #1;
        fall_cyc = cyc;
        send_good(8'hA5, NOM_BIT);
        send_good(8'h3C, NOM_BIT);
        wait_drain("b2b");
        check("b2b_dv_pulses", dv_cyc_q.size(), 2);
        if (dv_cyc_q.size() == 2) begin
            n_checks++;
            if (dv_cyc_q[0] - fall_cyc < 153 || dv_cyc_q[0] - fall_cyc > 155) begin
                n_fails++;
                $display("FAIL first_latency: got %0d clk, required 153..155", dv_cyc_q[0] - fall_cyc);
            end
            check("b2b_spacing", dv_cyc_q[1] - dv_cyc_q[0], 160);
        end
        check("b2b_byte_held", int'(o_rx_byte), 8'h3C);

        // Four-clock low glitch on an idle line.
        repeat (20) @(posedge clk);
        #1;
        busy_cycles = 0;
        fork
            begin
                rx = 1'b0;
                #(4 * CLK_PS);
                rx = 1'b1;
            end
            begin
                repeat (30) begin
                    @(negedge clk);
                    if (o_rx_busy) busy_cycles++;
                end
            end
        join
        n_checks++;
        if (busy_cycles < 1 || busy_cycles > 12) begin
            n_fails++;
            $display("FAIL glitch_busy: busy for %0d clk, required 1..12", busy_cycles);
        end
        quiet_window("glitch_quiet", 20);

        // 5A with stop bit low for three bit times, then recovery with 42.
        exp_q.push_back({1'b1, last_good});
        err_sent++;
        send_frame(8'h5A, NOM_BIT, 3);
        wait_drain("ferr");
        check("ferr_byte_held", int'(o_rx_byte), int'(last_good));
        #(2 * NOM_BIT);
        send_good(8'h42, NOM_BIT);
        wait_drain("after_ferr");

        // Reset during data bit 4 of FF, then 81.
        #(NOM_BIT);
        @(posedge clk);
        #1;
        rx = 1'b0;
        #(NOM_BIT);
        rx = 1'b1;
        #(4 * NOM_BIT + NOM_BIT / 2);
        rst_n = 1'b0;
        last_good = 8'h00;
        #(3 * CLK_PS);
        check("midreset_busy", int'(o_rx_busy), 0);
        check("midreset_byte", int'(o_rx_byte), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #(4 * NOM_BIT);
        dv_cyc_q.delete();
        send_good(8'h81, NOM_BIT);
        wait_drain("after_reset");
        check("after_reset_dv_pulses", dv_cyc_q.size(), 1);

        // Sweep all byte values with random +/-3% transmitter skew.
        for (int v = 0; v < 256; v++) begin
            skew = int'($urandom_range(0, 60)) - 30;
            send_good(8'(v), (NOM_BIT * (1000 + skew)) / 1000);
            #($urandom_range(0, 3000));
        end
        wait_drain("sweep");

        check("total_dv", dv_count, good_sent);
        check("total_ferr", ferr_count, err_sent);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #(64'd90000 * CLK_PS);
        $display("FAIL global_timeout: simulation exceeded time budget");
        n_fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $fatal(1, "timeout");
    end

endmodule
